fpu_command_sequencer: RTL and testbench

- Initiator side of the Floating_Point_Unit operand/result interface. Accepts FPU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives registered operands and opcode into the purely combinational FPU and holds them stable for a programmable multicycle settle window.
- Captures result and flags, then returns them with the command tag over a valid/ready response stream. Also keeps sticky exception status and a completion counter.

---
 rtl/fpu_command_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fpu_command_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_command_sequencer.sv
// Initiator-side sequencer for the combinational FPU: queues tagged commands, holds the
// operands stable for a settle window, then returns the captured result over a response stream.
module fpu_command_sequencer #(
  parameter int FORMAT_LENGTH = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int TAG_W         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [FORMAT_LENGTH-1:0] cmd_op_a,
  input  logic [FORMAT_LENGTH-1:0] cmd_op_b,
  input  logic [2:0]               cmd_operation,
  input  logic [1:0]               cmd_n_th,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [FORMAT_LENGTH-1:0] fpu_op_a,
  output logic [FORMAT_LENGTH-1:0] fpu_op_b,
  output logic [2:0]               fpu_operation,
  output logic [1:0]               fpu_n_th,
  input  logic [FORMAT_LENGTH-1:0] fpu_result,
  input  logic                     fpu_overflow,
  input  logic                     fpu_underflow,
  input  logic                     fpu_root_error,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FORMAT_LENGTH-1:0] rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [3:0]               rsp_flags,
  input  logic                     status_clr,
  output logic [3:0]               sticky_status,
  output logic [15:0]              done_count,
  output logic                     busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [FORMAT_LENGTH-1:0] op_a;
    logic [FORMAT_LENGTH-1:0] op_b;
    logic [2:0]               operation;
    logic [1:0]               n_th;
    logic [TAG_W-1:0]         tag;
  } cmd_t;

  cmd_t                     mem_q [FIFO_DEPTH];
  cmd_t                     mem_d [FIFO_DEPTH];
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count;
  logic                     full, empty, push, pop;
  cmd_t                     head;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FORMAT_LENGTH-1:0] fpu_op_a_q, fpu_op_a_d;
  logic [FORMAT_LENGTH-1:0] fpu_op_b_q, fpu_op_b_d;
  logic [2:0]               fpu_operation_q, fpu_operation_d;
  logic [1:0]               fpu_n_th_q, fpu_n_th_d;
  logic [FORMAT_LENGTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]         rsp_tag_q, rsp_tag_d;
  logic [3:0]               rsp_flags_q, rsp_flags_d;
  logic [3:0]               sticky_q, sticky_d;
  logic [15:0]              done_q, done_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = '{op_a: cmd_op_a, op_b: cmd_op_b, operation: cmd_operation,
                                     n_th: cmd_n_th, tag: cmd_tag};
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fpu_op_a_d      = fpu_op_a_q;
    fpu_op_b_d      = fpu_op_b_q;
    fpu_operation_d = fpu_operation_q;
    fpu_n_th_d      = fpu_n_th_q;
    rsp_result_d    = rsp_result_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_flags_d     = rsp_flags_q;
    done_d          = done_q;
    pop             = 1'b0;
    sticky_d        = status_clr ? 4'b0000 : sticky_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          rsp_tag_d = head.tag;
          if (head.operation <= 3'b100) begin
            fpu_op_a_d      = head.op_a;
            fpu_op_b_d      = head.op_b;
            fpu_operation_d = head.operation;
            fpu_n_th_d      = head.n_th;
            cnt_d           = CNT_W'(SETTLE_CYCLES - 1);
            state_d         = WAIT;
          end else begin
            // Unsupported opcodes bypass the FPU and answer immediately as illegal.
            rsp_result_d = '0;
            rsp_flags_d  = 4'b1000;
            state_d      = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = fpu_result;
          rsp_flags_d  = {1'b0, fpu_root_error, fpu_underflow, fpu_overflow};
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done_d   = done_q + 16'd1;
          sticky_d = sticky_d | rsp_flags_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      fpu_op_a_q      <= '0;
      fpu_op_b_q      <= '0;
      fpu_operation_q <= '0;
      fpu_n_th_q      <= '0;
      rsp_result_q    <= '0;
      rsp_tag_q       <= '0;
      rsp_flags_q     <= '0;
      sticky_q        <= '0;
      done_q          <= '0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fpu_op_a_q      <= fpu_op_a_d;
      fpu_op_b_q      <= fpu_op_b_d;
      fpu_operation_q <= fpu_operation_d;
      fpu_n_th_q      <= fpu_n_th_d;
      rsp_result_q    <= rsp_result_d;
      rsp_tag_q       <= rsp_tag_d;
      rsp_flags_q     <= rsp_flags_d;
      sticky_q        <= sticky_d;
      done_q          <= done_d;
    end
  end

  assign fpu_op_a      = fpu_op_a_q;
  assign fpu_op_b      = fpu_op_b_q;
  assign fpu_operation = fpu_operation_q;
  assign fpu_n_th      = fpu_n_th_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_flags     = rsp_flags_q;
  assign sticky_status = sticky_q;
  assign done_count    = done_q;
  assign busy          = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_fpu_command_sequencer.sv
// Bench for fpu_command_sequencer: a fake slow FPU, a transaction-level timing model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_fpu_command_sequencer;

  localparam int FL     = 32;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 3;
  localparam int TW     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [FL-1:0] cmd_op_a = '0;
  logic [FL-1:0] cmd_op_b = '0;
  logic [2:0]    cmd_operation = '0;
  logic [1:0]    cmd_n_th = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic [FL-1:0] fpu_op_a, fpu_op_b;
  logic [2:0]    fpu_operation;
  logic [1:0]    fpu_n_th;
  logic [FL-1:0] fpu_result;
  logic          fpu_overflow, fpu_underflow, fpu_root_error;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [FL-1:0] rsp_result;
  logic [TW-1:0] rsp_tag;
  logic [3:0]    rsp_flags;
  logic          status_clr = 1'b0;
  logic [3:0]    sticky_status;
  logic [15:0]   done_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fpu_command_sequencer #(
    .FORMAT_LENGTH(FL), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_operation(cmd_operation),
    .cmd_n_th(cmd_n_th), .cmd_tag(cmd_tag),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_operation(fpu_operation),
    .fpu_n_th(fpu_n_th), .fpu_result(fpu_result),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_root_error(fpu_root_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .status_clr(status_clr), .sticky_status(sticky_status),
    .done_count(done_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU arithmetic: arbitrary but deterministic, returns {root_error, underflow, overflow, result}.
  function automatic logic [34:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic [1:0] n);
    logic [31:0] r;
    logic        ovf, unf, rerr;
    case (op)
      3'd0:    r = (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      3'd1:    r = a - b;
      3'd2:    r = a ^ {b[15:0], b[31:16]};
      3'd3:    r = {a[31] ^ b[31], a[30:0] - b[30:0]};
      default: r = a >> n;
    endcase
    ovf  = (op == 3'd2) && (a[30:23] >= 8'hF0);
    unf  = (op == 3'd3) && (a[30:23] <= 8'h0F);
    rerr = (op == 3'd4) && a[31];
    return {rerr, unf, ovf, r};
  endfunction

  // The fake FPU only produces a correct answer once its inputs have been stable for SETTLE cycles.
  logic [34:0] fpu_good;
  logic [68:0] last_in = '0;
  int          age = 0;
  assign fpu_good = fpu_fn(fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th);
  assign fpu_result = (age >= SETTLE) ? fpu_good[31:0] : ~fpu_good[31:0];
  assign {fpu_root_error, fpu_underflow, fpu_overflow} =
         (age >= SETTLE) ? fpu_good[34:32] : ~fpu_good[34:32];
  always @(posedge clk) begin
    #1;
    if ({fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th} !== last_in) begin
      last_in = {fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th};
      age = 1;
    end else if (age < 1000) begin
      age++;
    end
  end

  function automatic void checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: commands waiting in the FIFO, the one being served, and its remaining latency.
  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
    logic        legal;
    logic [68:0] fpu_in;
  } entry_t;

  entry_t      mq[$];
  entry_t      cur;
  bit          have_cur = 0;
  int          cur_wait = 0;
  logic [68:0] m_fpu = '0;
  logic [15:0] m_done = '0;
  logic [3:0]  m_sticky = '0;

  function automatic entry_t make_entry(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [1:0] n, input logic [3:0] tag);
    entry_t      e;
    logic [34:0] f;
    e.tag    = tag;
    e.legal  = (op <= 3'd4);
    e.fpu_in = {a, b, op, n};
    f        = fpu_fn(a, b, op, n);
    e.res    = e.legal ? f[31:0] : 32'h0;
    e.flg    = e.legal ? {1'b0, f[34:32]} : 4'b1000;
    return e;
  endfunction

  always @(negedge clk) begin
    bit          exp_valid, acc, hs;
    logic [3:0]  st_next;
    if (!rst_n) begin
      mq.delete();
      have_cur = 0;
      cur_wait = 0;
      m_fpu    = '0;
      m_done   = '0;
      m_sticky = '0;
      checkOutput("reset_outputs",
                  {rsp_valid, busy, cmd_ready, done_count, sticky_status, rsp_flags, rsp_tag},
                  {1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 4'h0, 4'h0});
      checkOutput("reset_fpu_rsp", {fpu_op_a, fpu_op_b, rsp_result}, 80'h0);
    end else begin
      exp_valid = have_cur && (cur_wait == 0);
      checkOutput("cmd_ready", 80'(cmd_ready), 80'(mq.size() < DEPTH));
      checkOutput("busy", 80'(busy), 80'(have_cur || mq.size() > 0));
      checkOutput("rsp_valid", 80'(rsp_valid), 80'(exp_valid));
      checkOutput("fpu_inputs", 80'({fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th}), 80'(m_fpu));
      checkOutput("done_count", 80'(done_count), 80'(m_done));
      checkOutput("sticky_status", 80'(sticky_status), 80'(m_sticky));
      if (exp_valid)
        checkOutput("rsp_payload", 80'({rsp_result, rsp_tag, rsp_flags}), 80'({cur.res, cur.tag, cur.flg}));

      acc = cmd_valid && (mq.size() < DEPTH);
      hs  = exp_valid && rsp_ready;
      st_next = status_clr ? 4'h0 : m_sticky;
      if (have_cur) begin
        if (cur_wait > 0) cur_wait--;
        else if (hs) begin
          have_cur = 0;
          m_done   = m_done + 16'd1;
          st_next  = st_next | cur.flg;
        end
      end else if (mq.size() > 0) begin
        cur      = mq.pop_front();
        have_cur = 1;
        cur_wait = cur.legal ? SETTLE : 0;
        if (cur.legal) m_fpu = cur.fpu_in;
      end
      m_sticky = st_next;
      if (acc) mq.push_back(make_entry(cmd_op_a, cmd_op_b, cmd_operation, cmd_n_th, cmd_tag));
    end
  end

  // Presents one command at posedge+1 and returns after its acceptance edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [1:0] n, input logic [3:0] tag, output int acc_cyc);
    cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_operation = op; cmd_n_th = n; cmd_tag = tag;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (acc_cyc < 0) checkOutput("accept_timeout", 80'(1), 80'(0));
  endtask

  task automatic waitValid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin vcyc = cyc; break; end
    end
    if (vcyc < 0) checkOutput("valid_timeout", 80'(1), 80'(0));
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    checkOutput("idle_timeout", 80'(ok), 80'(1));
    @(posedge clk); #1;
  endtask

  task automatic resetDut();
    cmd_valid = 1'b0; rsp_ready = 1'b0; status_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    case ($urandom_range(0, 3))
      0:       e = 8'hF8;
      1:       e = 8'h05;
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    int acc, v, accs[6];
    logic [68:0] fpu_saved;
    logic [39:0] rsp_saved;
    logic [15:0] done_saved;
    bit          stale;
    bit          last_acc;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    resetDut();

    // 1.0 + 2.0 into an idle block.
    rsp_ready = 1'b1;
    applyStimulus(32'h3F800000, 32'h40000000, 3'd0, 2'd0, 4'd5, acc);
    waitValid(v);
    checkOutput("t1_latency", 80'(v - acc), 80'(5));
    checkOutput("t1_result", 80'(rsp_result), 80'h40400000);
    checkOutput("t1_tag", 80'(rsp_tag), 80'(5));
    checkOutput("t1_flags", 80'(rsp_flags), 80'(0));
    @(posedge clk); #1;
    checkOutput("t1_done", 80'(done_count), 80'(1));

    // Back-to-back commands against a stalled response port.
    rsp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          applyStimulus(randOperand(), randOperand(), 3'($urandom_range(0, 4)), 2'($urandom),
                        4'(k + 1), accs[k]);
      end
      begin
        waitValid(v);
        repeat (7) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    checkOutput("t2_five_accepted", 80'(accs[4] - accs[0]), 80'(4));
    checkOutput("t2_sixth_waits", 80'(accs[5] - accs[0]), 80'(14));
    waitIdle();
    checkOutput("t2_done", 80'(done_count), 80'(7));

    // Illegal opcode bypasses the FPU.
    fpu_saved = {fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th};
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 3'b110, 2'd1, 4'd2, acc);
    waitValid(v);
    checkOutput("t3_latency", 80'(v - acc), 80'(2));
    checkOutput("t3_payload", 80'({rsp_result, rsp_tag, rsp_flags}), 80'({32'h0, 4'd2, 4'b1000}));
    @(posedge clk); #1;
    checkOutput("t3_sticky3", 80'(sticky_status[3]), 80'(1));
    checkOutput("t3_fpu_untouched", 80'({fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th}), 80'(fpu_saved));

    // Overflow, then a clear coinciding with an underflow response.
    applyStimulus(32'h7F000000, 32'h7F000000, 3'd2, 2'd0, 4'd3, acc);
    waitValid(v);
    checkOutput("t4_ovf_flags", 80'(rsp_flags), 80'b0001);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(32'h00800000, 32'h3F800000, 3'd3, 2'd0, 4'd4, acc);
    waitValid(v);
    @(posedge clk); #1;
    rsp_ready = 1'b1; status_clr = 1'b1;
    @(posedge clk); #1;
    status_clr = 1'b0;
    checkOutput("t4_sticky_set_wins", 80'(sticky_status), 80'b0010);

    // Response held for 10 cycles.
    rsp_ready = 1'b0;
    applyStimulus(randOperand(), randOperand(), 3'd1, 2'd0, 4'd7, acc);
    waitValid(v);
    rsp_saved  = {rsp_result, rsp_tag, rsp_flags};
    done_saved = done_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t5_hold", 80'({rsp_valid, rsp_result, rsp_tag, rsp_flags, done_count}),
                  80'({1'b1, rsp_saved, done_saved}));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_done_once", 80'(done_count), 80'(done_saved + 16'd1));

    // Reset while WAITing with two commands queued.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      applyStimulus(randOperand(), randOperand(), 3'd0, 2'd0, 4'(8 + k), accs[k]);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_after_reset", 80'({busy, rsp_valid, cmd_ready}), 80'(3'b001));
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) stale = 1;
    end
    checkOutput("t6_no_stale_rsp", 80'(stale), 80'(0));

    // Random traffic against the model.
    @(posedge clk); #1;
    last_acc = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid     = ($urandom_range(0, 99) < 60);
        cmd_op_a      = randOperand();
        cmd_op_b      = randOperand();
        cmd_operation = 3'($urandom);
        cmd_n_th      = 2'($urandom);
        cmd_tag       = 4'($urandom);
      end
      rsp_ready  = ($urandom_range(0, 99) < 65);
      status_clr = ($urandom_range(0, 99) < 8);
      @(negedge clk);
      last_acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; status_clr = 1'b0;
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
